ahb_flash_reader_qspi: RTL and testbench

AHB_FLASH_READER_QSPI -- requirements
Module: ahb_flash_reader_qspi

---
 rtl/ahb_flash_reader_qspi.sv | 206 ++++++++++++++++++++
 tb/tb_ahb_flash_reader_qspi.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_flash_reader_qspi.sv
// AHB-Lite read-only window onto a quad-SPI flash (0xEB fast quad read), one word per fetch.
// Optional one-word read buffer enabled by defining QSPI_RD_BUF_EN.
module ahb_flash_reader_qspi #(
    parameter int DUMMY_CYCLES = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    input  logic [2:0]  HSIZE,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        fr_sck,
    output logic        fr_ce_n,
    output logic [3:0]  fr_dout,
    output logic        fr_douten,
    input  logic [3:0]  fr_din
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_DONE, S_DESEL
    } state_t;

    localparam logic [7:0] CMD_BYTE = 8'hEB;

    state_t      state_q, state_d;
    logic        phase_q, phase_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [21:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        sck_q, sck_d, ce_n_q, ce_n_d, douten_q, douten_d, hready_q, hready_d;
    logic [3:0]  dout_q, dout_d;
    logic [31:0] hrdata_q, hrdata_d;
    logic [23:0] addr_word;
    logic        accept, hit;

    logic unused_ok;
    assign unused_ok = ^{HWDATA, HSIZE, HADDR[31:24], HADDR[1:0], HTRANS[0]};

    function automatic logic [3:0] reload(state_t s);
        case (s)
            S_CMD:   reload = 4'd7;
            S_ADDR:  reload = 4'd5;
            S_MODE:  reload = 4'd1;
            S_DUMMY: reload = 4'(DUMMY_CYCLES - 1);
            S_DATA:  reload = 4'd7;
            default: reload = 4'd0;
        endcase
    endfunction

    function automatic logic in_sck(state_t s);
        in_sck = (s == S_CMD) || (s == S_ADDR) || (s == S_MODE) || (s == S_DUMMY) || (s == S_DATA);
    endfunction

    function automatic logic [31:0] byte_swap(logic [31:0] d);
        byte_swap = {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    assign accept = HSEL && HREADY && HTRANS[1] && !HWRITE &&
                    ((state_q == S_IDLE) || (state_q == S_DONE));

`ifdef QSPI_RD_BUF_EN
    logic [31:0] buf_data_q, buf_data_d;
    logic [21:0] buf_tag_q, buf_tag_d;
    logic        buf_valid_q, buf_valid_d;

    assign hit = accept && buf_valid_q && (buf_tag_q == HADDR[23:2]);
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef QSPI_RD_BUF_EN
        buf_data_d  = buf_data_q;
        buf_tag_d   = buf_tag_q;
        buf_valid_d = buf_valid_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept && !hit) begin
                    state_d = (state_q == S_DONE) ? S_DESEL : S_CMD;
                    addr_d  = HADDR[23:2];
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_DESEL: state_d = S_CMD;
            default: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    // fr_din is sampled on the edge that raises fr_sck
                    if (state_q == S_DATA) data_d = {data_q[27:0], fr_din};
                end else begin
                    phase_d = 1'b0;
                    if (cnt_q == 4'd0) begin
                        case (state_q)
                            S_CMD:   state_d = S_ADDR;
                            S_ADDR:  state_d = S_MODE;
                            S_MODE:  state_d = S_DUMMY;
                            S_DUMMY: state_d = S_DATA;
                            default: state_d = S_DONE;
                        endcase
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
        endcase

        if (state_d != state_q) begin
            phase_d = 1'b0;
            cnt_d   = reload(state_d);
        end

`ifdef QSPI_RD_BUF_EN
        if (state_d == S_DONE && state_q != S_DONE) begin
            buf_data_d  = byte_swap(data_d);
            buf_tag_d   = addr_q;
            buf_valid_d = 1'b1;
        end
`endif

        // Outputs are decoded from next-state values so every pin comes straight off a flop.
        addr_word = {addr_d, 2'b00};
        sck_d     = in_sck(state_d) && phase_d;
        ce_n_d    = !in_sck(state_d);
        douten_d  = (state_d == S_CMD) || (state_d == S_ADDR) || (state_d == S_MODE);
        hready_d  = (state_d == S_IDLE) || (state_d == S_DONE);
        case (state_d)
            S_CMD:   dout_d = {3'b110, CMD_BYTE[cnt_d[2:0]]};
            S_ADDR:  dout_d = addr_word[{cnt_d[2:0], 2'b00} +: 4];
            default: dout_d = 4'h0;
        endcase
        if (state_d == S_DONE) begin
            hrdata_d = byte_swap(data_d);
        end else if (hit) begin
`ifdef QSPI_RD_BUF_EN
            hrdata_d = buf_data_q;
`else
            hrdata_d = 32'h0;
`endif
        end else begin
            hrdata_d = 32'h0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; all next values come from always_comb.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= S_IDLE;
            phase_q  <= 1'b0;
            cnt_q    <= 4'd0;
            addr_q   <= 22'd0;
            data_q   <= 32'd0;
            sck_q    <= 1'b0;
            ce_n_q   <= 1'b1;
            douten_q <= 1'b0;
            dout_q   <= 4'h0;
            hready_q <= 1'b1;
            hrdata_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            sck_q    <= sck_d;
            ce_n_q   <= ce_n_d;
            douten_q <= douten_d;
            dout_q   <= dout_d;
            hready_q <= hready_d;
            hrdata_q <= hrdata_d;
        end
    end

`ifdef QSPI_RD_BUF_EN
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            buf_data_q  <= 32'd0;
            buf_tag_q   <= 22'd0;
            buf_valid_q <= 1'b0;
        end else begin
            buf_data_q  <= buf_data_d;
            buf_tag_q   <= buf_tag_d;
            buf_valid_q <= buf_valid_d;
        end
    end
`endif

    assign HREADYOUT = hready_q;
    assign HRDATA    = hrdata_q;
    assign fr_sck    = sck_q;
    assign fr_ce_n   = ce_n_q;
    assign fr_dout   = dout_q;
    assign fr_douten = douten_q;

endmodule

// File: tb/tb_ahb_flash_reader_qspi.sv
// Directed bench for ahb_flash_reader_qspi with a behavioural quad-read flash model.
// Buffer checks are compiled in when QSPI_RD_BUF_EN is defined.
module tb_ahb_flash_reader_qspi;

    localparam int DUMMY = 4;
    localparam int DATA_START = 16 + DUMMY;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = 32'h0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic        HREADY;
    logic [31:0] HWDATA = 32'h0;
    logic [2:0]  HSIZE = 3'b010;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        fr_sck, fr_ce_n, fr_douten;
    logic [3:0]  fr_dout;
    logic [3:0]  fr_din = 4'h0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] flash_word = 32'h11223344;
    int          rise_cnt = 0;
    int          ce_falls = 0;
    int          douten_err = 0;
    logic [7:0]  cmd_bits = 8'h0;
    logic [23:0] addr_bits = 24'h0;

    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahb_flash_reader_qspi #(.DUMMY_CYCLES(DUMMY)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HSIZE(HSIZE),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .fr_sck(fr_sck), .fr_ce_n(fr_ce_n),
        .fr_dout(fr_dout), .fr_douten(fr_douten), .fr_din(fr_din)
    );

    // Flash model: observes the command/address stream and serves flash_word in data phase.
    always @(negedge fr_ce_n or posedge fr_sck) begin
        if (!fr_sck) begin
            rise_cnt   = 0;
            ce_falls   = ce_falls + 1;
            cmd_bits   = 8'h0;
            addr_bits  = 24'h0;
            douten_err = 0;
        end else begin
            rise_cnt = rise_cnt + 1;
            if (rise_cnt <= 8) cmd_bits = {cmd_bits[6:0], fr_dout[0]};
            else if (rise_cnt <= 14) addr_bits = {addr_bits[19:0], fr_dout};
            if ((rise_cnt <= 16) != fr_douten) douten_err = douten_err + 1;
        end
    end

    always @(negedge fr_sck) begin
        if (rise_cnt >= DATA_START && rise_cnt < DATA_START + 8)
            fr_din = 4'(flash_word >> (28 - 4 * (rise_cnt - DATA_START)));
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic wr);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = a;
    endtask

    task automatic idle_bus();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!HREADYOUT && n < 200) begin
            n++;
            step();
        end
    endtask

    // Issues a read, waits for the DONE cycle, samples HRDATA, then moves one cycle on.
    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int n);
        addr_phase(a, 1'b0);
        step();
        idle_bus();
        wait_done(n);
        d = HRDATA;
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ce_n"},   32'(fr_ce_n),   32'd1);
        check({tag, "_sck"},    32'(fr_sck),    32'd0);
        check({tag, "_douten"}, 32'(fr_douten), 32'd0);
        check({tag, "_dout"},   32'(fr_dout),   32'd0);
        check({tag, "_hready"}, 32'(HREADYOUT), 32'd1);
        check({tag, "_hrdata"}, HRDATA,         32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int n, n2, falls0;
        logic all_ok;

        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        #3 HRESET = 1'b0;
        step(); step();

        // Reset asserted while idle
        #2 HRESET = 1'b1;
        #1 check_reset_outputs("idle_rst");
        @(posedge HCLK);
        #3 HRESET = 1'b0;
        step();

        // Single read of 0x104
        flash_word = 32'h11223344;
        falls0 = ce_falls;
        do_read(32'h0000_0104, d, n);
        check("rd104_wait", 32'(n), 32'd56);
        check("rd104_data", d, 32'h44332211);
        check("rd104_cmd", 32'(cmd_bits), 32'hEB);
        check("rd104_addr", 32'(addr_bits), 32'h000104);
        check("rd104_douten", 32'(douten_err), 32'd0);
        check("rd104_sck_count", 32'(rise_cnt), 32'd28);
        check("rd104_ce_falls", 32'(ce_falls - falls0), 32'd1);
        check("idle_hrdata", HRDATA, 32'h0);
        check("idle_ce_n", 32'(fr_ce_n), 32'd1);

        // Back-to-back reads 0x0 then 0x4, second issued in the DONE cycle
        flash_word = 32'h01234567;
        addr_phase(32'h0, 1'b0);
        step();
        idle_bus();
        wait_done(n);
        check("b2b1_wait", 32'(n), 32'd56);
        check("b2b1_data", HRDATA, 32'h67452301);
        check("b2b1_addr", 32'(addr_bits), 32'h000000);
        check("b2b_done_ce_n", 32'(fr_ce_n), 32'd1);
        addr_phase(32'h4, 1'b0);
        step();
        idle_bus();
        check("b2b_desel_ce_n", 32'(fr_ce_n), 32'd1);
        check("b2b_desel_hready", 32'(HREADYOUT), 32'd0);
        step();
        check("b2b_cmd_ce_n", 32'(fr_ce_n), 32'd0);
        wait_done(n2);
        check("b2b2_latency", 32'(n2 + 2), 32'd58);
        check("b2b2_data", HRDATA, 32'h67452301);
        check("b2b2_addr", 32'(addr_bits), 32'h000004);
        step();

        // Write is zero-wait with no flash activity
        falls0 = ce_falls;
        addr_phase(32'h10, 1'b1);
        step();
        idle_bus();
        HWDATA = 32'hFFFF_FFFF;
        all_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            all_ok = all_ok & HREADYOUT & fr_ce_n;
            step();
        end
        check("wr_zero_wait", 32'(all_ok), 32'd1);
        check("wr_ce_falls", 32'(ce_falls - falls0), 32'd0);
        check("wr_hrdata", HRDATA, 32'h0);
        flash_word = 32'hA1B2C3D4;
        do_read(32'h10, d, n);
        check("rd10_wait", 32'(n), 32'd56);
        check("rd10_data", d, 32'hD4C3B2A1);
        check("rd10_addr", 32'(addr_bits), 32'h000010);

        // Reset at T+40 of a fetch
        flash_word = 32'h11223344;
        addr_phase(32'h104, 1'b0);
        step();
        idle_bus();
        repeat (39) step();
        check("midrst_active", 32'(fr_ce_n), 32'd0);
        #2 HRESET = 1'b1;
        #1 check_reset_outputs("mid_rst");
        @(posedge HCLK);
        #3 HRESET = 1'b0;
        step();
        do_read(32'h104, d, n);
        check("post_rst_wait", 32'(n), 32'd56);
        check("post_rst_data", d, 32'h44332211);

`ifdef QSPI_RD_BUF_EN
        // 0x104 is buffered from the previous fetch; flash content changed to prove the source
        flash_word = 32'h55667788;
        falls0 = ce_falls;
        do_read(32'h104, d, n);
        check("buf_hit_wait", 32'(n), 32'd0);
        check("buf_hit_data", d, 32'h44332211);
        check("buf_hit_ce_falls", 32'(ce_falls - falls0), 32'd0);
        do_read(32'h108, d, n);
        check("buf_miss_wait", 32'(n), 32'd56);
        check("buf_miss_data", d, 32'h88776655);
        check("buf_miss_ce_falls", 32'(ce_falls - falls0), 32'd1);
        do_read(32'h104, d, n);
        check("buf_evict_wait", 32'(n), 32'd56);
        check("buf_evict_data", d, 32'h88776655);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
